fpu_wb_regs: RTL and testbench

// - Wishbone-slave register front end of the user-project FPU, at base 0x3000_0000.
// - Holds operands A/B/C, rounding mode and operation word, and launches operations.
// - Computes sign-injection (FSGNJ/FSGNJN/FSGNJX) internally.
// - Forwards all other ops to an external FPU core and captures its result/flags.

---
 rtl/fpu_wb_if.sv | 26 ++
 rtl/fpu_wb_regs.sv | 194 +++++++++++++++++++
 tb/tb_fpu_wb_regs.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_wb_if.sv
// Wishbone slave bus bundle for the FPU register front end.
// Signals keep the slave-side Wishbone names (_i = into the slave, _o = out of it).
//   wbs_cyc_i, wbs_stb_i, wbs_we_i  : cycle, strobe, write enable
//   wbs_sel_i[3:0]                  : byte-lane selects
//   wbs_adr_i[31:0], wbs_dat_i[31:0]: address and write data
//   wbs_ack_o, wbs_dat_o[31:0]      : acknowledge and read data
interface fpu_wb_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fpu_wb_regs.sv
// Wishbone register front end of the user-project FPU.
// Holds operands A/B/C, rounding mode and the operation word; launches
// operations. Sign-injection is computed locally, every other operation is
// handed to an external core whose result and flags are captured here.
// Ports:
//   wb_clk_i, wb_rst_n : clock, asynchronous active-low reset
//   wb                 : Wishbone slave bus (fpu_wb_if.slave)
//   a, b, c            : operand registers to the core
//   rm                 : rounding mode / sign-inject variant
//   op_in, valid_in    : one-hot operation and its valid bit, as written
//   core_start         : one-cycle start pulse for core operations
//   core_done, core_result, core_flags : core completion handshake
//   irq                : level interrupt, equal to status.done
module fpu_wb_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  fpu_wb_if.slave     wb,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] c,
  output logic [2:0]  rm,
  output logic [11:0] op_in,
  output logic        valid_in,
  output logic        core_start,
  input  logic        core_done,
  input  logic [31:0] core_result,
  input  logic [4:0]  core_flags,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no operation in flight
    ST_SGNJ = 2'd1,  // sign-inject result is produced this cycle
    ST_BAD  = 2'd2,  // malformed op word, invalid-op result this cycle
    ST_CORE = 2'd3   // waiting for core_done
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] result_q, result_nxt;
  logic [4:0]  flags_q, flags_nxt;
  logic        done_q;
  logic        set_done;
  logic        core_start_nxt;
  logic        hit, req, wr;
  logic [2:0]  idx;
  logic [31:0] op_wdata;
  logic        start, busy, sgn;
  logic [31:0] rdata;
  logic        unused_bits;

  // Byte-lane merge: selected bytes come from new_v, the rest keep old_v.
  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction

  assign hit      = (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  // A request is taken only while ack is low, so ack is a single-cycle pulse
  // even when the master keeps stb asserted.
  assign req      = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o & hit;
  assign wr       = req & wb.wbs_we_i;
  assign idx      = wb.wbs_adr_i[4:2];
  assign op_wdata = merge({19'd0, valid_in, op_in}, wb.wbs_dat_i, wb.wbs_sel_i);
  assign busy     = (state != ST_IDLE);
  // Launch only on a 0->1 edge of valid_in; while busy the register still
  // updates but nothing starts.
  assign start    = wr && (idx == 3'd7) && !valid_in && op_wdata[12] && !busy;
  assign irq      = done_q;
  assign unused_bits = ^{wb.wbs_adr_i[1:0], op_wdata[31:13]};

  always_comb begin
    case (rm)
      3'b000:  sgn = b[31];
      3'b001:  sgn = ~b[31];
      3'b010:  sgn = a[31] ^ b[31];
      default: sgn = a[31];
    endcase
  end

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt      = state;
    result_nxt     = result_q;
    flags_nxt      = flags_q;
    set_done       = 1'b0;
    core_start_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (!$onehot(op_wdata[11:0])) begin
            state_nxt = ST_BAD;
          end else if (op_wdata[10]) begin
            state_nxt = ST_SGNJ;
          end else begin
            state_nxt      = ST_CORE;
            core_start_nxt = 1'b1;
          end
        end
      end
      ST_SGNJ: begin
        // NaN payloads pass through untouched; only the sign bit is replaced.
        result_nxt = {sgn, a[30:0]};
        flags_nxt  = 5'b00000;
        set_done   = 1'b1;
        state_nxt  = ST_IDLE;
      end
      ST_BAD: begin
        result_nxt = 32'd0;
        flags_nxt  = 5'b10000;
        set_done   = 1'b1;
        state_nxt  = ST_IDLE;
      end
      ST_CORE: begin
        if (core_done) begin
          result_nxt = core_result;
          flags_nxt  = core_flags;
          set_done   = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    case (idx)
      3'd0: rdata = a;
      3'd1: rdata = b;
      3'd2: rdata = c;
      3'd3: rdata = result_q;
      3'd4: rdata = {27'd0, flags_q};
      3'd5: rdata = {29'd0, rm};
      3'd6: rdata = {30'd0, busy, done_q};
      3'd7: rdata = {19'd0, valid_in, op_in};
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= 32'd0;
      a            <= 32'd0;
      b            <= 32'd0;
      c            <= 32'd0;
      rm           <= 3'd0;
      op_in        <= 12'd0;
      valid_in     <= 1'b0;
      core_start   <= 1'b0;
      result_q     <= 32'd0;
      flags_q      <= 5'd0;
      done_q       <= 1'b0;
    end else begin
      wb.wbs_ack_o <= req;
      if (req && !wb.wbs_we_i) wb.wbs_dat_o <= rdata;
      core_start <= core_start_nxt;
      result_q   <= result_nxt;
      flags_q    <= flags_nxt;
      if (wr) begin
        case (idx)
          3'd0: a <= merge(a, wb.wbs_dat_i, wb.wbs_sel_i);
          3'd1: b <= merge(b, wb.wbs_dat_i, wb.wbs_sel_i);
          3'd2: c <= merge(c, wb.wbs_dat_i, wb.wbs_sel_i);
          3'd5: if (wb.wbs_sel_i[0]) rm <= wb.wbs_dat_i[2:0];
          3'd7: {valid_in, op_in} <= op_wdata[12:0];
          default: ;  // RESULT, FLAGS, STATUS hold no writable data bits
        endcase
      end
      // Completion beats a same-cycle write-1-to-clear.
      if (set_done)
        done_q <= 1'b1;
      else if (start)
        done_q <= 1'b0;
      else if (wr && idx == 3'd6 && wb.wbs_sel_i[0] && wb.wbs_dat_i[0])
        done_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_wb_regs.sv
// Self-checking bench for fpu_wb_regs: a cycle-level reference model of the
// register block compared against the DUT on every falling edge, plus
// directed bus transactions with hand-computed expected read values.
module tb_fpu_wb_regs;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a, b, c;
  logic [2:0]  rm;
  logic [11:0] op_in;
  logic        valid_in, core_start, irq;
  logic        core_done = 1'b0;
  logic [31:0] core_result = 32'd0;
  logic [4:0]  core_flags = 5'd0;

  int n_cmp = 0;
  int n_fail = 0;
  int cs_cnt = 0;

  always #5 clk = ~clk;

  fpu_wb_if wb();

  fpu_wb_regs #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .wb          (wb),
    .a           (a),
    .b           (b),
    .c           (c),
    .rm          (rm),
    .op_in       (op_in),
    .valid_in    (valid_in),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .core_flags  (core_flags),
    .irq         (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_a, m_b, m_c, m_res, m_dat;
  logic [2:0]  m_rm;
  logic [11:0] m_op;
  logic [4:0]  m_flags;
  logic        m_val, m_done, m_busy, m_ack, m_cs, m_due, m_bad;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] i);
    logic [31:0] regs [8];
    regs[0] = m_a;  regs[1] = m_b;  regs[2] = m_c;  regs[3] = m_res;
    regs[4] = {27'd0, m_flags};
    regs[5] = {29'd0, m_rm};
    regs[6] = {30'd0, m_busy, m_done};
    regs[7] = {19'd0, m_val, m_op};
    return regs[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic        req, w1c, set_d, old_busy, st, nxt_cs, s;
    logic [2:0]  i;
    logic [31:0] nop;
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_c = 0; m_res = 0; m_dat = 0; m_rm = 0; m_op = 0;
      m_flags = 0; m_val = 0; m_done = 0; m_busy = 0; m_ack = 0; m_cs = 0;
      m_due = 0; m_bad = 0;
    end else begin
      old_busy = m_busy; set_d = 0; w1c = 0; nxt_cs = 0;
      i   = wb.wbs_adr_i[4:2];
      req = wb.wbs_cyc_i && wb.wbs_stb_i && !m_ack && (wb.wbs_adr_i[31:5] == BASE[31:5]);
      if (req && !wb.wbs_we_i) m_dat = model_read(i);
      if (m_due) begin
        m_due = 0; m_busy = 0; set_d = 1;
        if (m_bad) begin
          m_res = 0; m_flags = 5'h10;
        end else begin
          if (m_rm == 0)      s = m_b[31];
          else if (m_rm == 1) s = !m_b[31];
          else if (m_rm == 2) s = m_a[31] ^ m_b[31];
          else                s = m_a[31];
          m_res = {s, m_a[30:0]}; m_flags = 0;
        end
      end else if (m_busy && core_done) begin
        m_res = core_result; m_flags = core_flags; m_busy = 0; set_d = 1;
      end
      if (req && wb.wbs_we_i) begin
        case (i)
          3'd0: m_a = lanes(m_a, wb.wbs_dat_i, wb.wbs_sel_i);
          3'd1: m_b = lanes(m_b, wb.wbs_dat_i, wb.wbs_sel_i);
          3'd2: m_c = lanes(m_c, wb.wbs_dat_i, wb.wbs_sel_i);
          3'd5: if (wb.wbs_sel_i[0]) m_rm = wb.wbs_dat_i[2:0];
          3'd6: w1c = wb.wbs_sel_i[0] && wb.wbs_dat_i[0];
          3'd7: begin
            nop = lanes({19'd0, m_val, m_op}, wb.wbs_dat_i, wb.wbs_sel_i);
            st  = !m_val && nop[12] && !old_busy;
            m_op = nop[11:0]; m_val = nop[12];
            if (st) begin
              m_busy = 1; m_done = 0;
              if ($countones(nop[11:0]) != 1) begin m_bad = 1; m_due = 1; end
              else if (nop[10])               begin m_bad = 0; m_due = 1; end
              else                            nxt_cs = 1;
            end
          end
          default: ;
        endcase
      end
      if (set_d)    m_done = 1;
      else if (w1c) m_done = 0;
      m_ack = req; m_cs = nxt_cs;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("ack", {31'd0, wb.wbs_ack_o}, {31'd0, m_ack});
    check("dat_o", wb.wbs_dat_o, m_dat);
    check("a", a, m_a);
    check("b", b, m_b);
    check("c", c, m_c);
    check("rm", {29'd0, rm}, {29'd0, m_rm});
    check("op_in", {20'd0, op_in}, {20'd0, m_op});
    check("valid_in", {31'd0, valid_in}, {31'd0, m_val});
    check("core_start", {31'd0, core_start}, {31'd0, m_cs});
    check("irq", {31'd0, irq}, {31'd0, m_done});
    if (core_start) cs_cnt++;
  end

  // ---------------- bus helpers ----------------
  task automatic wb_xfer(input logic w, input logic [31:0] adr, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdat, output int lat);
    @(negedge clk);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = w;
    wb.wbs_adr_i = adr; wb.wbs_dat_i = d; wb.wbs_sel_i = s;
    lat = 0; rdat = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (wb.wbs_ack_o === 1'b1) begin
        lat = k; rdat = wb.wbs_dat_o;
        break;
      end
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] r; int lat;
    wb_xfer(1'b1, BASE | {27'd0, off}, d, s, r, lat);
    check($sformatf("wr%02h_ack_lat", off), lat, 1);
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string name);
    logic [31:0] r; int lat;
    wb_xfer(1'b0, BASE | {27'd0, off}, 32'd0, 4'hF, r, lat);
    check({name, "_ack_lat"}, lat, 1);
    check(name, r, exp);
  endtask

  task automatic pulse_done(input logic [31:0] r, input logic [4:0] f);
    @(negedge clk);
    core_done = 1; core_result = r; core_flags = f;
    @(negedge clk);
    core_done = 0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] r; int lat; int cs0; int acks;
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1;

    for (int k = 0; k < 8; k++) rd(5'(k * 4), 32'd0, $sformatf("reset_rd%0d", k));

    // FSGNJ: sign taken from B
    wr(5'h00, 32'h3F80_0000); wr(5'h04, 32'hC000_0000); wr(5'h14, 0); wr(5'h1C, 32'h1400);
    check("a_port", a, 32'h3F80_0000);
    check("b_port", b, 32'hC000_0000);
    check("op_port", {20'd0, op_in}, 32'h400);
    check("valid_port", {31'd0, valid_in}, 1);
    rd(5'h0C, 32'hBF80_0000, "sgnj_res");
    rd(5'h10, 32'd0, "sgnj_flags");
    rd(5'h18, 32'd1, "sgnj_status");

    // FSGNJN
    wr(5'h1C, 32'h0400); wr(5'h14, 1); wr(5'h1C, 32'h1400);
    rd(5'h0C, 32'h3F80_0000, "sgnjn_res");
    // FSGNJX
    wr(5'h1C, 32'h0400); wr(5'h14, 2); wr(5'h1C, 32'h1400);
    rd(5'h0C, 32'hBF80_0000, "sgnjx_res");
    wr(5'h00, 32'hBF80_0000); wr(5'h04, 32'hBF80_0000);
    wr(5'h1C, 32'h0400); wr(5'h1C, 32'h1400);
    rd(5'h0C, 32'h3F80_0000, "sgnjx_neg_res");
    // undefined rm keeps A's sign
    wr(5'h14, 5); wr(5'h1C, 32'h0400); wr(5'h1C, 32'h1400);
    rd(5'h0C, 32'hBF80_0000, "sgnj_rm5_res");

    // byte lanes, RO write, out-of-range address
    wr(5'h00, 32'd0); wr(5'h00, 32'hFFFF_FFFF, 4'b0010);
    rd(5'h00, 32'h0000_FF00, "a_lane1");
    wr(5'h0C, 32'h1234_5678);
    rd(5'h0C, 32'hBF80_0000, "result_ro");
    wb_xfer(1'b1, BASE + 32'h20, 32'hAAAA_AAAA, 4'hF, r, lat);
    check("outside_no_ack", lat, 0);
    rd(5'h00, 32'h0000_FF00, "a_after_outside");

    // malformed op words
    wr(5'h1C, 0); wr(5'h1C, 32'h1003);
    rd(5'h0C, 32'd0, "multihot_res");
    rd(5'h10, 32'h10, "multihot_flags");
    rd(5'h1C, 32'h1003, "multihot_op");
    wr(5'h18, 1);
    rd(5'h18, 32'd0, "w1c_status");
    wr(5'h1C, 0); wr(5'h1C, 32'h1000);
    rd(5'h18, 32'd1, "zero_op_status");
    rd(5'h10, 32'h10, "zero_op_flags");

    // core operation
    wr(5'h1C, 0);
    cs0 = cs_cnt;
    wr(5'h1C, 32'h1001);
    rd(5'h18, 32'd2, "add_busy");
    wr(5'h1C, 32'h0001); wr(5'h1C, 32'h1002);  // start while busy: ignored
    check("cs_pulses", cs_cnt - cs0, 1);
    check("op_busy_upd", {20'd0, op_in}, 32'h2);
    rd(5'h18, 32'd2, "still_busy");
    pulse_done(32'h4040_0000, 5'b00001);
    check("irq_set", {31'd0, irq}, 1);
    rd(5'h0C, 32'h4040_0000, "core_res");
    rd(5'h10, 32'h1, "core_flags");
    rd(5'h18, 32'd1, "core_status");
    wr(5'h18, 1);
    check("irq_clr", {31'd0, irq}, 0);
    pulse_done(32'hDEAD_BEEF, 5'h1F);  // idle: ignored
    rd(5'h0C, 32'h4040_0000, "idle_done_ignored");

    // done-set and W1C in the same cycle: set wins
    wr(5'h1C, 0); wr(5'h1C, 32'h1001);
    @(negedge clk);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 1;
    wb.wbs_adr_i = BASE + 32'h18; wb.wbs_dat_i = 1; wb.wbs_sel_i = 4'hF;
    core_done = 1; core_result = 32'h4080_0000; core_flags = 0;
    @(negedge clk);
    core_done = 0;
    check("simul_ack", {31'd0, wb.wbs_ack_o}, 1);
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    rd(5'h18, 32'd1, "set_wins");
    rd(5'h0C, 32'h4080_0000, "simul_res");

    // stb held high: ack pulses every other cycle
    @(negedge clk);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 0; wb.wbs_adr_i = BASE + 32'h14;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (wb.wbs_ack_o === 1'b1) acks++;
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
    check("held_stb_acks", acks, 2);

    // reset while the core is busy
    wr(5'h1C, 0); wr(5'h1C, 32'h1001);
    @(negedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    check("rst_a", a, 0);
    check("rst_valid", {31'd0, valid_in}, 0);
    #2 rst_n = 1;
    pulse_done(32'h1234_5678, 5'h1F);
    rd(5'h0C, 32'd0, "rst_res");
    rd(5'h10, 32'd0, "rst_flags");
    rd(5'h18, 32'd0, "rst_status");
    rd(5'h1C, 32'd0, "rst_op");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
